// File: rtl/pic10_pc_stack_pkg.sv
// Shared defaults and action encodings for the PIC10 program counter block.
package pic10_pc_stack_pkg;

  localparam int PC_W_DEF        = 9;
  localparam int STACK_DEPTH_DEF = 2;
  localparam int RESET_VEC_DEF   = 0;

  // Action chosen for the PC each cycle, in priority order ret > call > load > inc.
  localparam logic [2:0] ACT_HOLD = 3'd0;
  localparam logic [2:0] ACT_INC  = 3'd1;
  localparam logic [2:0] ACT_LOAD = 3'd2;
  localparam logic [2:0] ACT_CALL = 3'd3;
  localparam logic [2:0] ACT_RET  = 3'd4;

endpackage

// File: rtl/pic10_pc_stack_ret_stack.sv
// Shift-register LIFO used as the hardware return stack.
// Entry 0 is the top. A push while full discards the oldest entry; a pop
// while empty leaves the level at zero. The bottom entry keeps its value on pop.
module pic10_ret_stack
  import pic10_pc_stack_pkg::*;
#(
  parameter int W     = PC_W_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [LVL_W-1:0] level
);

  logic [DEPTH-1:0][W-1:0] entries_q, entries_d;
  logic [LVL_W-1:0]        level_q, level_d;

  // Next stack contents: pop shifts toward the top, push shifts away from it.
  always_comb begin
    entries_d = entries_q;
    level_d   = level_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_d[i] = entries_q[i+1];
      end
      if (level_q != '0) begin
        level_d = level_q - LVL_W'(1);
      end
    end else if (push) begin
      entries_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        entries_d[i] = entries_q[i-1];
      end
      if (level_q != LVL_W'(DEPTH)) begin
        level_d = level_q + LVL_W'(1);
      end
    end
  end

  // Stack state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '0;
      level_q   <= '0;
    end else begin
      entries_q <= entries_d;
      level_q   <= level_d;
    end
  end

  assign top   = entries_q[0];
  assign level = level_q;

endmodule

// File: rtl/pic10_pc_stack.sv
// Program counter for the PIC10-class core with an integrated return stack.
// Optional macro PC_STACK_ERR_EN adds a sticky stk_err output that flags
// stack overflow (call when full) or underflow (ret when empty).
module pic10_pc_stack
  import pic10_pc_stack_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(RESET_VEC_DEF),
  parameter int              LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_pc,
  input  logic             skip,
  input  logic             load_pc,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  load_addr,
  output logic [PC_W-1:0]  pc_bus,
  output logic [LVL_W-1:0] stk_level,
  output logic             stk_full,
  output logic             stk_empty
`ifdef PC_STACK_ERR_EN
  ,
  output logic             stk_err
`endif
);

  logic [2:0]      act;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1, pc_plus2;
  logic [PC_W-1:0] stack_top;
  logic            do_push, do_pop;

  // Pick exactly one action per cycle; lower-priority strobes are dropped.
  always_comb begin
    act = ACT_HOLD;
    if (ret) begin
      act = ACT_RET;
    end else if (call) begin
      act = ACT_CALL;
    end else if (load_pc) begin
      act = ACT_LOAD;
    end else if (inc_pc) begin
      act = ACT_INC;
    end
  end

  assign pc_plus1 = pc_q + PC_W'(1);
  assign pc_plus2 = pc_q + PC_W'(2);
  assign do_push  = (act == ACT_CALL);
  assign do_pop   = (act == ACT_RET);

  // Next PC from the selected action; adders wrap modulo 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    case (act)
      ACT_INC:  pc_d = skip ? pc_plus2 : pc_plus1;
      ACT_LOAD: pc_d = load_addr;
      ACT_CALL: pc_d = load_addr;
      ACT_RET:  pc_d = stack_top;
      default:  pc_d = pc_q;
    endcase
  end

  // PC register; reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  pic10_ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH),
    .LVL_W (LVL_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_plus1),
    .top   (stack_top),
    .level (stk_level)
  );

  assign pc_bus    = pc_q;
  assign stk_full  = (stk_level == LVL_W'(STACK_DEPTH));
  assign stk_empty = (stk_level == '0);

`ifdef PC_STACK_ERR_EN
  logic err_q, err_d;

  // Sticky error: set by overflow or underflow, cleared only by reset.
  always_comb begin
    err_d = err_q | (do_push & stk_full) | (do_pop & stk_empty);
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign stk_err = err_q;
`endif

endmodule

// File: tb/tb_pic10_pc_stack.sv
// Directed self-checking bench for pic10_pc_stack (PC_W=9, STACK_DEPTH=2, RESET_VEC=0).
// Compile with +define+PC_STACK_ERR_EN to also check the sticky stk_err output.
module tb_pic10_pc_stack;

  logic       clk = 1'b0;
  logic       reset;
  logic       inc_pc, skip, load_pc, call, ret;
  logic [8:0] load_addr;
  logic [8:0] pc_bus;
  logic [1:0] stk_level;
  logic       stk_full, stk_empty;
`ifdef PC_STACK_ERR_EN
  logic       stk_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pic10_pc_stack #(
    .PC_W        (9),
    .STACK_DEPTH (2),
    .RESET_VEC   (9'h000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inc_pc    (inc_pc),
    .skip      (skip),
    .load_pc   (load_pc),
    .call      (call),
    .ret       (ret),
    .load_addr (load_addr),
    .pc_bus    (pc_bus),
    .stk_level (stk_level),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
`ifdef PC_STACK_ERR_EN
    ,
    .stk_err   (stk_err)
`endif
  );

  // Drive one cycle of strobes, let the edge take them, then release them.
  task automatic applyStimulus(input logic r, input logic inc, input logic skp,
                               input logic ld, input logic cl, input logic rt,
                               input logic [8:0] addr);
    reset     = r;
    inc_pc    = inc;
    skip      = skp;
    load_pc   = ld;
    call      = cl;
    ret       = rt;
    load_addr = addr;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    inc_pc  = 1'b0;
    skip    = 1'b0;
    load_pc = 1'b0;
    call    = 1'b0;
    ret     = 1'b0;
  endtask

  // Compare PC, level and the full/empty decodes against hand-computed values.
  task automatic checkOutput(input string tag, input logic [8:0] exp_pc,
                             input logic [1:0] exp_lvl);
    logic exp_full, exp_empty;
    exp_full  = (exp_lvl == 2'd2);
    exp_empty = (exp_lvl == 2'd0);
    compared++;
    assert (pc_bus === exp_pc) else begin
      mismatched++;
      $error("[TB] FAIL %s pc_bus observed=%h expected=%h", tag, pc_bus, exp_pc);
    end
    compared++;
    assert (stk_level === exp_lvl) else begin
      mismatched++;
      $error("[TB] FAIL %s stk_level observed=%0d expected=%0d", tag, stk_level, exp_lvl);
    end
    compared++;
    assert (stk_full === exp_full) else begin
      mismatched++;
      $error("[TB] FAIL %s stk_full observed=%b expected=%b", tag, stk_full, exp_full);
    end
    compared++;
    assert (stk_empty === exp_empty) else begin
      mismatched++;
      $error("[TB] FAIL %s stk_empty observed=%b expected=%b", tag, stk_empty, exp_empty);
    end
  endtask

`ifdef PC_STACK_ERR_EN
  task automatic checkErr(input string tag, input logic exp_err);
    compared++;
    assert (stk_err === exp_err) else begin
      mismatched++;
      $error("[TB] FAIL %s stk_err observed=%b expected=%b", tag, stk_err, exp_err);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; inc_pc = 1'b0; skip = 1'b0; load_pc = 1'b0;
    call = 1'b0; ret = 1'b0; load_addr = '0;

    // 1. reset, sequential increments, reset mid-run
    applyStimulus(1, 0, 0, 0, 0, 0, 9'h000);
    applyStimulus(1, 0, 0, 0, 0, 0, 9'h000);
    checkOutput("reset", 9'h000, 2'd0);
`ifdef PC_STACK_ERR_EN
    checkErr("reset_err", 1'b0);
`endif
    applyStimulus(0, 1, 0, 0, 0, 0, 9'h000);
    checkOutput("inc1", 9'h001, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'h000);
    checkOutput("inc2", 9'h002, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'h000);
    checkOutput("inc3", 9'h003, 2'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h040);
    checkOutput("call_pre_reset", 9'h040, 2'd1);
    applyStimulus(1, 1, 0, 0, 1, 0, 9'h055);
    checkOutput("reset_mid_run", 9'h000, 2'd0);

    // 2. wrap and skip
    applyStimulus(0, 0, 0, 1, 0, 0, 9'h1FE);
    checkOutput("load_1fe", 9'h1FE, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'h000);
    checkOutput("inc_1ff", 9'h1FF, 2'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 9'h000);
    checkOutput("inc_wrap", 9'h000, 2'd0);
    applyStimulus(0, 1, 1, 0, 0, 0, 9'h000);
    checkOutput("skip", 9'h002, 2'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 9'h000);
    checkOutput("skip_alone_holds", 9'h002, 2'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 9'h1FF);
    applyStimulus(0, 1, 1, 0, 0, 0, 9'h000);
    checkOutput("skip_wrap", 9'h001, 2'd0);

    // 3. call / ret
    applyStimulus(0, 0, 0, 1, 0, 0, 9'h010);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h100);
    checkOutput("call_100", 9'h100, 2'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h180);
    checkOutput("call_180", 9'h180, 2'd2);
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h000);
    checkOutput("ret_101", 9'h101, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h000);
    checkOutput("ret_011", 9'h011, 2'd0);
`ifdef PC_STACK_ERR_EN
    checkErr("no_err_yet", 1'b0);
`endif

    // 4. overflow and underflow
    applyStimulus(0, 0, 0, 1, 0, 0, 9'h010);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h100);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h180);
    applyStimulus(0, 0, 0, 1, 0, 0, 9'h0A0);
    checkOutput("load_keeps_stack", 9'h0A0, 2'd2);
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h050);
    checkOutput("call_overflow", 9'h050, 2'd2);
`ifdef PC_STACK_ERR_EN
    checkErr("err_after_overflow", 1'b1);
`endif
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h000);
    checkOutput("ret_0a1", 9'h0A1, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h000);
    checkOutput("ret_101_b", 9'h101, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 9'h000);
    checkOutput("ret_underflow", 9'h101, 2'd0);

    // 5. same-cycle priority
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h030);
    checkOutput("call_030", 9'h030, 2'd1);
    applyStimulus(0, 1, 0, 1, 1, 1, 9'h077);
    checkOutput("ret_wins", 9'h102, 2'd0);
    applyStimulus(0, 1, 0, 1, 0, 0, 9'h0C0);
    checkOutput("load_beats_inc", 9'h0C0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 9'h1AA);
    checkOutput("idle_holds", 9'h0C0, 2'd0);
    applyStimulus(0, 1, 1, 0, 1, 0, 9'h033);
    checkOutput("call_beats_inc", 9'h033, 2'd1);

    // 6. sticky error cleared only by reset
`ifdef PC_STACK_ERR_EN
    checkErr("err_sticky", 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 9'h000);
    checkErr("err_cleared", 1'b0);
`else
    applyStimulus(1, 0, 0, 0, 0, 0, 9'h000);
`endif
    checkOutput("final_reset", 9'h000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
